dm_bus_bridge: RTL and testbench

//  Load/store stage between the ALU/RU datapath and an external data-memory bus; consumes ALURES (address),

---
 rtl/dm_bus_bridge.sv | 138 +++++++++++++
 tb/tb_dm_bus_bridge.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/dm_bus_bridge.sv
// dm_bus_bridge: core load/store to req/ack data-bus bridge with byte lanes, load extension and timeout
module dm_bus_bridge #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic        dm_wr,
    input  logic        dm_rd,
    input  logic [2:0]  dm_ctrl,
    output logic [31:0] dm_rdata,
    output logic        stall,
    output logic        fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);
    localparam int TW = $clog2(TIMEOUT);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t        state_q, state_d;
    logic          bus_req_q, bus_req_d, bus_we_q, bus_we_d, fault_q, fault_d;
    logic [31:0]   bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d, dm_rdata_q, dm_rdata_d;
    logic [3:0]    bus_be_q, bus_be_d;
    logic [2:0]    ctrl_q, ctrl_d;
    logic [1:0]    off_q, off_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          acc, bad;
    logic [3:0]    be;
    logic [31:0]   wd, w, ld;

    always_comb begin
        acc = dm_wr | dm_rd;
        bad = dm_ctrl == 3'b011 || dm_ctrl[2:1] == 2'b11
            || (dm_ctrl[1:0] == 2'b01 && dm_addr[0])
            || (dm_ctrl == 3'b010 && dm_addr[1:0] != 2'b00);
        be = dm_ctrl[1] ? 4'b1111 : ((dm_ctrl[0] ? 4'b0011 : 4'b0001) << dm_addr[1:0]);
        wd = dm_ctrl[1] ? dm_wdata : dm_ctrl[0] ? {2{dm_wdata[15:0]}} : {4{dm_wdata[7:0]}};
        w  = bus_rdata >> {off_q, 3'b000};
        ld = ctrl_q[1] ? w
           : ctrl_q[0] ? {{16{~ctrl_q[2] & w[15]}}, w[15:0]}
           : {{24{~ctrl_q[2] & w[7]}}, w[7:0]};
    end

    always_comb begin
        state_d     = state_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        dm_rdata_d  = dm_rdata_q;
        ctrl_d      = ctrl_q;
        off_d       = off_q;
        timer_d     = timer_q;
        fault_d     = 1'b0;
        stall       = 1'b0;
        fault       = fault_q;
        dm_rdata    = dm_rdata_q;
        case (state_q)
            IDLE: begin
                if (acc && bad) begin
                    fault      = 1'b1;
                    dm_rdata   = '0;
                    dm_rdata_d = '0;
                end else if (acc) begin
                    stall       = 1'b1;
                    bus_req_d   = 1'b1;
                    bus_we_d    = dm_wr;
                    bus_addr_d  = {dm_addr[31:2], 2'b00};
                    bus_be_d    = be;
                    bus_wdata_d = wd;
                    ctrl_d      = dm_ctrl;
                    off_d       = dm_addr[1:0];
                    timer_d     = '0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                stall   = 1'b1;
                timer_d = timer_q + 1'b1;
                if (bus_ack) begin
                    bus_req_d  = 1'b0;
                    dm_rdata_d = bus_we_q ? dm_rdata_q : ld;
                    state_d    = DONE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    bus_req_d  = 1'b0;
                    dm_rdata_d = '0;
                    fault_d    = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                timer_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            dm_rdata_q  <= '0;
            ctrl_q      <= '0;
            off_q       <= '0;
            timer_q     <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            dm_rdata_q  <= dm_rdata_d;
            ctrl_q      <= ctrl_d;
            off_q       <= off_d;
            timer_q     <= timer_d;
            fault_q     <= fault_d;
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
endmodule

// File: tb/tb_dm_bus_bridge.sv
// tb_dm_bus_bridge: directed and randomized accesses checked against a byte-level reference model
module tb_dm_bus_bridge;
    localparam int TIMEOUT = 16;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] dm_addr = '0, dm_wdata = '0, dm_rdata, bus_addr, bus_wdata, bus_rdata = '0;
    logic        dm_wr = 1'b0, dm_rd = 1'b0, stall, fault, bus_req, bus_we, bus_ack = 1'b0;
    logic [2:0]  dm_ctrl = '0;
    logic [3:0]  bus_be;
    int          checks = 0, errors = 0;
    logic [31:0] model_rd = '0;

    dm_bus_bridge #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wr(dm_wr),
        .dm_rd(dm_rd), .dm_ctrl(dm_ctrl), .dm_rdata(dm_rdata), .stall(stall), .fault(fault),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [2:0] c);
        case (c)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] c, input logic [1:0] off,
                                             input logic [31:0] word);
        int sz = size_of(c);
        logic [31:0] v = '0;
        for (int j = 0; j < sz; j++) v[8*j +: 8] = word[8*(int'(off) + j) +: 8];
        if (!c[2] && sz < 4 && v[8*sz-1])
            for (int j = sz; j < 4; j++) v[8*j +: 8] = 8'hff;
        return v;
    endfunction

    // dly: BUSY cycle index (0 = first cycle bus_req is high) on which ack arrives; <0 = never
    task automatic access(input logic wr, input logic rd, input logic [2:0] ctrl, input logic [31:0] addr,
                          input logic [31:0] wd, input int dly, input logic [31:0] rdat);
        int sz, nstall, nbusy;
        bit bad, acked;
        logic [3:0] ebe;
        logic [31:0] ewd;
        sz  = size_of(ctrl);
        bad = (sz == 0) ? 1'b1 : (int'(addr[1:0]) % sz != 0);
        for (int k = 0; k < 4; k++) begin
            ebe[k] = sz != 0 && k >= int'(addr[1:0]) && k < int'(addr[1:0]) + sz;
            ewd[8*k +: 8] = (sz == 0) ? 8'h00 : wd[8*(k % sz) +: 8];
        end
        @(negedge clk);
        dm_wr = wr; dm_rd = rd; dm_ctrl = ctrl; dm_addr = addr; dm_wdata = wd;
        #1;
        if (bad) begin
            chk("bad_fault", 32'(fault), 32'd1);
            chk("bad_stall", 32'(stall), 32'd0);
            chk("bad_rdata", dm_rdata, 32'd0);
            chk("bad_req", 32'(bus_req), 32'd0);
            model_rd = '0;
            @(negedge clk);
            dm_wr = 1'b0; dm_rd = 1'b0;
            #1;
            chk("bad_after_fault", 32'(fault), 32'd0);
            chk("bad_after_req", 32'(bus_req), 32'd0);
            chk("bad_after_rdata", dm_rdata, model_rd);
            return;
        end
        chk("go_stall", 32'(stall), 32'd1);
        chk("go_fault", 32'(fault), 32'd0);
        nstall = int'(stall);
        nbusy = 0;
        acked = 1'b0;
        @(negedge clk);
        dm_wr = 1'b0; dm_rd = 1'b0; dm_addr = $urandom; dm_ctrl = 3'($urandom); dm_wdata = $urandom;
        for (int i = 0; i < TIMEOUT && !acked; i++) begin
            if (i > 0) @(negedge clk);
            bus_ack = (i == dly);
            bus_rdata = (i == dly) ? rdat : $urandom;
            #1;
            if (i == 0) begin
                chk("bus_we", 32'(bus_we), 32'(wr));
                chk("bus_addr", bus_addr, {addr[31:2], 2'b00});
                chk("bus_be", 32'(bus_be), 32'(ebe));
                if (wr) chk("bus_wdata", bus_wdata, ewd);
            end
            chk("busy_req", 32'(bus_req), 32'd1);
            chk("busy_fault", 32'(fault), 32'd0);
            nstall += int'(stall);
            nbusy++;
            acked = (i == dly);
        end
        @(negedge clk);
        bus_ack = 1'b0; bus_rdata = $urandom;
        #1;
        if (!acked) model_rd = '0;
        else if (!wr) model_rd = load_val(ctrl, addr[1:0], rdat);
        chk("done_stall", 32'(stall), 32'd0);
        chk("done_req", 32'(bus_req), 32'd0);
        chk("done_fault", 32'(fault), 32'(!acked));
        chk("done_rdata", dm_rdata, model_rd);
        chk("stall_cycles", 32'(nstall), 32'(acked ? dly + 2 : TIMEOUT + 1));
        chk("req_cycles", 32'(nbusy), 32'(acked ? dly + 1 : TIMEOUT));
    endtask

    task automatic idle_check();
        @(negedge clk);
        dm_wr = 1'b0; dm_rd = 1'b0; bus_ack = $urandom_range(0, 1) == 1;
        #1;
        chk("idle_stall", 32'(stall), 32'd0);
        chk("idle_fault", 32'(fault), 32'd0);
        chk("idle_req", 32'(bus_req), 32'd0);
        chk("idle_rdata", dm_rdata, model_rd);
        bus_ack = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_we", 32'(bus_we), 32'd0);
        chk("rst_be", 32'(bus_be), 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_rdata", dm_rdata, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_check();
        access(1'b0, 1'b1, 3'b010, 32'h100, 32'h0, 1, 32'hDEADBEEF);
        chk("lw_spec", dm_rdata, 32'hDEADBEEF);
        access(1'b0, 1'b1, 3'b000, 32'h103, 32'h0, 0, 32'h80123456);
        chk("lb_spec", dm_rdata, 32'hFFFFFF80);
        access(1'b0, 1'b1, 3'b100, 32'h103, 32'h0, 2, 32'h80123456);
        chk("lbu_spec", dm_rdata, 32'h00000080);
        access(1'b1, 1'b0, 3'b001, 32'h202, 32'h1234ABCD, 0, 32'h0);
        chk("sh_keeps_rdata", dm_rdata, 32'h00000080);
        access(1'b1, 1'b1, 3'b101, 32'h10, 32'hCAFEF00D, 3, 32'hFFFFFFFF);
        idle_check();
        access(1'b0, 1'b1, 3'b010, 32'h101, 32'h0, 0, 32'h0);
        access(1'b0, 1'b1, 3'b011, 32'h100, 32'h0, 0, 32'h0);
        access(1'b0, 1'b1, 3'b010, 32'h300, 32'h0, -1, 32'h0);
        idle_check();
        access(1'b0, 1'b1, 3'b101, 32'h302, 32'h0, TIMEOUT - 1, 32'h8001ABCD);
        chk("hu_timeout_edge", dm_rdata, 32'h00008001);
        @(negedge clk);
        dm_rd = 1'b1; dm_ctrl = 3'b010; dm_addr = 32'h40;
        @(negedge clk);
        dm_rd = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_rd = '0;
        chk("rst_mid_req", 32'(bus_req), 32'd0);
        chk("rst_mid_stall", 32'(stall), 32'd0);
        chk("rst_mid_rdata", dm_rdata, model_rd);
        @(negedge clk);
        rst_n = 1'b1;
        access(1'b0, 1'b1, 3'b010, 32'h44, 32'h0, 1, 32'h13579BDF);
        for (int n = 0; n < 80; n++) begin
            logic wr, rd;
            int d;
            wr = $urandom_range(0, 1) == 1;
            rd = !wr || $urandom_range(0, 1) == 1;
            d = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 5));
            access(wr, rd, 3'($urandom), $urandom, $urandom, d, $urandom);
            if ($urandom_range(0, 3) == 0) idle_check();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
